seg7_step_monitor: RTL and testbench

//  Receive-side partner of the up/down mod-6 counter with 7-segment output.

---
 rtl/seg7_step_monitor.sv | 153 +++++++++++++++
 tb/tb_seg7_step_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_step_monitor.sv
// Seven-segment receive-side monitor: synchronise, debounce and decode seg_n,
// then classify each accepted digit change as a mod-MODULUS up/down/bad step.
module seg7_step_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int MODULUS       = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] seg_n,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       new_digit,
  output logic       illegal,
  output logic       step_up,
  output logic       step_down,
  output logic       step_err
);

  localparam int CW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(STABLE_CYCLES - 1);
  localparam logic [3:0] MOD = 4'(MODULUS);
  localparam logic [6:0] OFF = 7'b1111111;

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_DIGIT,
    ST_ILLEGAL
  } state_t;

  state_t state, state_n;

  logic [6:0]    s1, s2, cand, acc;
  logic [CW-1:0] cnt;
  logic          hist_ok, hist_n;
  logic [3:0]    digit_n;
  logic          nd_n, il_n, up_n, dn_n, er_n;
  logic          accept;
  logic          dec_ok;
  logic [3:0]    dec_val;
  logic [3:0]    up_val, dn_val;

  assign accept = (cnt == CNT_MAX) && (s2 == cand)
                  && (cand != acc);

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    unique case (1'b1)
      (cand == 7'b0000001): dec_val = 4'd0;
      (cand == 7'b1001111): dec_val = 4'd1;
      (cand == 7'b0010010): dec_val = 4'd2;
      (cand == 7'b0000110): dec_val = 4'd3;
      (cand == 7'b1001100): dec_val = 4'd4;
      (cand == 7'b0100100): dec_val = 4'd5;
      (cand == 7'b0100000): dec_val = 4'd6;
      (cand == 7'b0001111): dec_val = 4'd7;
      (cand == 7'b0000000): dec_val = 4'd8;
      (cand == 7'b0000100): dec_val = 4'd9;
      default:              dec_ok  = 1'b0;
    endcase
  end

  // digit doubles as the previous-digit history
  assign up_val = (digit + 4'd1) % MOD;
  assign dn_val = (digit == 4'd0) ? (MOD - 4'd1)
                                  : (digit - 4'd1);

  always_comb begin
    state_n = state;
    hist_n  = hist_ok;
    digit_n = digit;
    nd_n    = 1'b0;
    il_n    = 1'b0;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    er_n    = 1'b0;
    if (accept) begin
      if (cand == OFF) begin
        state_n = ST_BLANK;
        hist_n  = 1'b0;
      end else if (dec_ok) begin
        state_n = ST_DIGIT;
        digit_n = dec_val;
        nd_n    = 1'b1;
        hist_n  = 1'b1;
        if (hist_ok) begin
          if (dec_val >= MOD)
            er_n = 1'b1;
          else if (dec_val == up_val)
            up_n = 1'b1;
          else if (dec_val == dn_val)
            dn_n = 1'b1;
          else
            er_n = 1'b1;
        end
      end else begin
        state_n = ST_ILLEGAL;
        il_n    = 1'b1;
        hist_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1   <= OFF;
      s2   <= OFF;
      cand <= OFF;
      acc  <= OFF;
      cnt  <= '0;
    end else begin
      s1 <= seg_n;
      s2 <= s1;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      if (accept)
        acc <= cand;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_BLANK;
      hist_ok   <= 1'b0;
      digit     <= 4'd0;
      new_digit <= 1'b0;
      illegal   <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      state     <= state_n;
      hist_ok   <= hist_n;
      digit     <= digit_n;
      new_digit <= nd_n;
      illegal   <= il_n;
      step_up   <= up_n;
      step_down <= dn_n;
      step_err  <= er_n;
    end
  end

  assign digit_valid = (state == ST_DIGIT);
  assign blank       = (state == ST_BLANK);

endmodule

// File: tb/tb_seg7_step_monitor.sv
// Directed bench for seg7_step_monitor: expected events are queued
// by the stimulus and popped by a monitor on every observable change.
module tb_seg7_step_monitor;

  logic       clock;
  logic       reset;
  logic [6:0] seg_n;
  logic [3:0] digit;
  logic       digit_valid, blank;
  logic       new_digit, illegal;
  logic       step_up, step_down, step_err;

  seg7_step_monitor #(
    .STABLE_CYCLES(4),
    .MODULUS(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .seg_n(seg_n),
    .digit(digit),
    .digit_valid(digit_valid),
    .blank(blank),
    .new_digit(new_digit),
    .illegal(illegal),
    .step_up(step_up),
    .step_down(step_down),
    .step_err(step_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       nd;
    logic       il;
    logic       up;
    logic       dn;
    logic       er;
    logic [3:0] dg;
    logic       dv;
    logic       bl;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push(input logic nd, input logic il,
                      input logic up, input logic dn,
                      input logic er, input int dg,
                      input logic dv, input logic bl);
    ev_t e;
    e = '{nd, il, up, dn, er, 4'(dg), dv, bl};
    q.push_back(e);
  endtask

  task automatic exp_digit(input int d, input logic up,
                           input logic dn, input logic er);
    push(1'b1, 1'b0, up, dn, er, d, 1'b1, 1'b0);
  endtask

  // Called at posedge+2; returns at posedge+2 after n edges.
  task automatic drive(input logic [6:0] p, input int n);
    seg_n = p;
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  logic pdv, pbl;
  ev_t  mon_a, mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      pdv = 1'b0;
      pbl = 1'b1;
    end else begin
      mon_a = '{new_digit, illegal, step_up, step_down,
                step_err, digit, digit_valid, blank};
      if (new_digit || illegal || step_up || step_down ||
          step_err || digit_valid != pdv || blank != pbl) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h", mon_a);
        end else begin
          mon_e = q.pop_front();
          if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL event: got %h want %h",
                     mon_a, mon_e);
          end
        end
      end
      pdv = digit_valid;
      pbl = blank;
    end
  end

  initial begin
    reset = 1'b0;
    seg_n = pat(0);
    repeat (3) @(posedge clock);
    #1;
    check("reset_pulses", {3'b0, new_digit, illegal,
          step_up, step_down, step_err}, 8'h00);
    check("reset_blank", {7'b0, blank}, 8'h01);
    check("reset_valid", {7'b0, digit_valid}, 8'h00);
    check("reset_digit", {4'b0, digit}, 8'h00);
    #1;
    exp_digit(0, 0, 0, 0);
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("latency_early", {7'b0, new_digit}, 8'h00);
    @(posedge clock);
    #1;
    check("latency_nd", {7'b0, new_digit}, 8'h01);
    check("latency_digit", {4'b0, digit}, 8'h00);
    #1;
    repeat (3) @(posedge clock);
    #2;

    for (int d = 1; d <= 5; d++) begin
      exp_digit(d, 1, 0, 0);
      drive(pat(d), 10);
    end
    exp_digit(0, 1, 0, 0);
    drive(pat(0), 10);

    exp_digit(5, 0, 1, 0);
    drive(pat(5), 10);
    exp_digit(4, 0, 1, 0);
    drive(pat(4), 10);
    exp_digit(2, 0, 0, 1);
    drive(pat(2), 10);

    exp_digit(3, 1, 0, 0);
    drive(pat(3), 10);
    drive(pat(4), 3);
    drive(pat(3), 10);
    check("glitch_digit", {4'b0, digit}, 8'h03);

    push(0, 1, 0, 0, 0, 3, 0, 0);
    drive(7'b0111111, 10);
    exp_digit(4, 0, 0, 0);
    drive(pat(4), 10);
    exp_digit(5, 1, 0, 0);
    drive(pat(5), 10);
    exp_digit(6, 0, 0, 1);
    drive(pat(6), 10);
    exp_digit(7, 0, 0, 1);
    drive(pat(7), 10);
    push(0, 0, 0, 0, 0, 7, 0, 1);
    drive(7'b1111111, 10);

    drive(pat(1), 4);
    reset = 1'b0;
    #1;
    check("midrst_pulses", {3'b0, new_digit, illegal,
          step_up, step_down, step_err}, 8'h00);
    check("midrst_blank", {7'b0, blank}, 8'h01);
    check("midrst_digit", {4'b0, digit}, 8'h00);
    repeat (2) @(posedge clock);
    #2;
    exp_digit(1, 0, 0, 0);
    reset = 1'b1;
    drive(pat(1), 12);

    for (int i = 0; i < 200 && q.size() != 0; i++)
      @(posedge clock);
    repeat (5) @(posedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0",
               q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
